text_line_renderer: RTL and testbench
=====================================

// Module: text_line_renderer
// PURPOSE
//  Pipelined overlay renderer for one scaled line of NUM_CHARS characters at a programmable screen origin.
//  Owns a writable character buffer and a glyph ROM, and turns a stream of pixel coordinates into a per-pixel draw bit.
//  Sits between the VGA timing generator (hpos/vpos/pix_valid) and the colour mux.
//  Supersedes single-character combinational drawing: string support, power-of-2 scale, frame-synchronous origin.
// PARAMETERS
//  NUM_CHARS   16  characters per line (buffer depth), >=1
//  COORD_W     12  width of hpos/vpos/origin
//  GLYPH_W     7   glyph columns
//  GLYPH_H     7   glyph rows
//  CHAR_GAP    1   blank columns after each glyph; CELL_W = GLYPH_W+CHAR_GAP
//  SCALE_W     3   width of scale_log2 (pixel scale = 1<<scale_log2)
//  BLINK_FRAMES 30 frames per blink half-period (BLINK_EN only)
// PORTS
//  clk         in   1        pixel clock
//  rst_n       in   1        asynchronous reset, active low
//  frame_start in   1        one-cycle pulse at start of frame; latches origin/scale
//  h_ori       in   COORD_W  line origin X (top-left pixel of char 0)
//  v_ori       in   COORD_W  line origin Y
//  scale_log2  in   SCALE_W  log2 of pixel scale
//  pix_valid   in   1        hpos/vpos valid this cycle
//  hpos, vpos  in   COORD_W  current pixel coordinate
//  wr_en       in   1        char buffer write strobe
//  wr_addr     in   clog2(NUM_CHARS) buffer index
//  wr_data     in   8        ASCII code
//  wr_blink    in   1        blink attribute (present only with BLINK_EN)
//  draw        out  1        pixel is glyph foreground
//  draw_valid  out  1        draw qualifies pix_valid delayed 3 cycles
// BEHAVIOUR
//  Reset: draw=0, draw_valid=0, pipeline valids=0, shadow origin/scale=0, all buffer entries=8'h20, blink attrs=0.
//  Shadow regs: h_ori/v_ori/scale_log2 captured on frame_start only; mid-frame input changes ignored until next pulse.
//  Pipeline, fixed latency 3: pix_valid at cycle t -> draw_valid at t+3; no stalls, no backpressure.
//   S0: register hpos/vpos; dx=hpos-h_ori, dy=vpos-v_ori in COORD_W+1 bits; neg flags = hpos<h_ori | vpos<v_ori.
//   S1: cx=dx>>scale, ry=dy>>scale; idx=cx/CELL_W, gc=cx%CELL_W (constant divide); registered buffer read at idx.
//   S2: glyph ROM lookup (row ry, col gc) -> draw.
//  draw=1 only when: valid, !neg, ry<GLYPH_H, idx<NUM_CHARS, gc<GLYPH_W, and glyph bit set; else 0.
//  Glyph bit order: bit[ry*GLYPH_W+gc], row 0 = top, col 0 = left.
//  Codes outside 8'h20..8'h7E render blank.
//  Buffer write: wr_addr>=NUM_CHARS ignored. Read-first: read of same index in the write cycle returns old code.
//  Reset mid-frame: pipeline flushed, draw_valid low from assertion; resumes at first pix_valid after release.
//  Simultaneous frame_start and pix_valid: that pixel already uses the new origin/scale.
//  Right-edge clipping is not performed; callers keep the line on-screen.
// CONFIGURATION
//  TEXT_LINE_BLINK_EN defined:
//   - buffer entries are 9 bits {blink,code}; port wr_blink exists.
//   - frame counter counts frame_start pulses 0..BLINK_FRAMES-1, then toggles blink_phase; counter and phase reset to 0.
//   - draw forced 0 for entries with blink=1 while blink_phase=1.
//  Not defined: no wr_blink port, no counter, 8-bit entries, behaviour as above.
// STRUCTURE
//  Package text_pkg: GLYPH_W/GLYPH_H defaults, glyph_t (GLYPH_W*GLYPH_H bits), CHAR_SPACE=8'h20.
//  Sub-module glyph_rom: combinational ASCII -> glyph_t; instantiated once in S2.
//  Top holds shadow regs, buffer, pipeline regs, blink counter.
// TESTING
//  1. Reset, frame_start with origin (100,50), scale 0; sweep row 50 -> draw matches 'space' glyph (all 0), draw_valid exactly 3 cycles after pix_valid.
//  2. Write "AB" at idx 0,1, scale 1; scan rows 50..63 -> 'A' pattern in 14x14 at X 100..113, gap X 114..115, 'B' at 116..129.
//  3. Pixels at (99,50), (100,49), (100,64), X=100+NUM_CHARS*16 -> draw=0.
//  4. Change h_ori mid-frame to 200 -> no shift until next frame_start; pulse coincident with pix_valid uses 200.
//  5. Write idx 0 = 'C' in the same cycle S1 reads idx 0 -> that pixel uses old glyph, next pixel uses 'C'; wr_addr=NUM_CHARS -> no change.
//  6. (BLINK_EN) 'X' blink=1, BLINK_FRAMES=2 -> drawn frames 0-1, blank frames 2-3, drawn 4-5; assert rst_n low mid-frame -> draw/draw_valid=0 immediately.

Source files
------------

// File: rtl/text_pkg.sv
// Shared glyph geometry, glyph type and font-building helper for the text line renderer.
// Optional blink attribute support elsewhere is enabled by TEXT_LINE_BLINK_EN.
package text_pkg;

  localparam int unsigned GLYPH_W    = 7;
  localparam int unsigned GLYPH_H    = 7;
  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int unsigned GIDX_W     = $clog2(GLYPH_BITS);

  typedef logic [GLYPH_BITS-1:0] glyph_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Builds a glyph from seven 5-pixel rows (MSB = leftmost) centred in columns 1..5.
  function automatic glyph_t g5(input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] r3,
                                input logic [4:0] r4, input logic [4:0] r5,
                                input logic [4:0] r6);
    logic [4:0] rows [7];
    glyph_t     g;
    rows = '{r0, r1, r2, r3, r4, r5, r6};
    g    = '0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 5; c++) begin
        g[GIDX_W'(r * GLYPH_W + c + 1)] = rows[3'(r)][3'(4 - c)];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/text_line_renderer_glyph_rom.sv
// Combinational ASCII to glyph lookup; lowercase folds onto uppercase, unmapped codes are blank.
// Shared by all builds (TEXT_LINE_BLINK_EN does not change the font).
module glyph_rom
  import text_pkg::*;
(
  input  logic [7:0]            code,
  output logic [GLYPH_BITS-1:0] glyph_c
);

  logic [7:0] up_code;

  always_comb begin
    up_code = code;
    if (code >= 8'h61 && code <= 8'h7A) up_code = code - 8'h20;
  end

  always_comb begin
    glyph_c = '0;
    case (up_code)
      8'h21: glyph_c = g5(5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00100);
      8'h2D: glyph_c = g5(5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
      8'h2E: glyph_c = g5(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01100, 5'b01100);
      8'h3A: glyph_c = g5(5'b00000, 5'b01100, 5'b01100, 5'b00000, 5'b01100, 5'b01100, 5'b00000);
      8'h30: glyph_c = g5(5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110);
      8'h31: glyph_c = g5(5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110);
      8'h32: glyph_c = g5(5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111);
      8'h33: glyph_c = g5(5'b11110, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110);
      8'h34: glyph_c = g5(5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010);
      8'h35: glyph_c = g5(5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110);
      8'h36: glyph_c = g5(5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110);
      8'h37: glyph_c = g5(5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000);
      8'h38: glyph_c = g5(5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110);
      8'h39: glyph_c = g5(5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100);
      8'h41: glyph_c = g5(5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001);
      8'h42: glyph_c = g5(5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110);
      8'h43: glyph_c = g5(5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110);
      8'h44: glyph_c = g5(5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11110);
      8'h45: glyph_c = g5(5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111);
      8'h46: glyph_c = g5(5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000);
      8'h47: glyph_c = g5(5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111);
      8'h48: glyph_c = g5(5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001);
      8'h49: glyph_c = g5(5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110);
      8'h4A: glyph_c = g5(5'b00111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b01100);
      8'h4B: glyph_c = g5(5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001);
      8'h4C: glyph_c = g5(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111);
      8'h4D: glyph_c = g5(5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001);
      8'h4E: glyph_c = g5(5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001);
      8'h4F: glyph_c = g5(5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110);
      8'h50: glyph_c = g5(5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000);
      8'h51: glyph_c = g5(5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10010, 5'b01101);
      8'h52: glyph_c = g5(5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001);
      8'h53: glyph_c = g5(5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110);
      8'h54: glyph_c = g5(5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100);
      8'h55: glyph_c = g5(5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110);
      8'h56: glyph_c = g5(5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100);
      8'h57: glyph_c = g5(5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010);
      8'h58: glyph_c = g5(5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001, 5'b10001);
      8'h59: glyph_c = g5(5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100);
      8'h5A: glyph_c = g5(5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111);
      default: glyph_c = '0;
    endcase
  end

endmodule

// File: rtl/text_line_renderer.sv
// Three-stage scaled text line overlay: pixel coordinate in, glyph foreground bit out.
// Define TEXT_LINE_BLINK_EN to add per-character blink attributes and the frame blink counter.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int unsigned NUM_CHARS    = 16,
  parameter int unsigned COORD_W      = 12,
  parameter int unsigned CHAR_GAP     = 1,
  parameter int unsigned SCALE_W      = 3,
`ifdef TEXT_LINE_BLINK_EN
  parameter int unsigned BLINK_FRAMES = 30,
`endif
  localparam int unsigned AW          = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] h_ori,
  input  logic [COORD_W-1:0] v_ori,
  input  logic [SCALE_W-1:0] scale_log2,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_data,
`ifdef TEXT_LINE_BLINK_EN
  input  logic               wr_blink,
`endif
  output logic               draw,
  output logic               draw_valid
);

  localparam int unsigned CELL_W = GLYPH_W + CHAR_GAP;
  localparam int unsigned ROW_W  = $clog2(GLYPH_H);
  localparam int unsigned COL_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
`ifdef TEXT_LINE_BLINK_EN
  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
`else
  localparam int unsigned ENTRY_W = 8;
`endif

  logic [COORD_W-1:0] h_ori_q, h_ori_d, v_ori_q, v_ori_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [ENTRY_W-1:0] cbuf_q [NUM_CHARS];
  logic [ENTRY_W-1:0] cbuf_d [NUM_CHARS];
  logic [ENTRY_W-1:0] wr_entry;

  logic               v0_q, v0_d, neg0_q, neg0_d;
  logic [COORD_W-1:0] dx0_q, dx0_d, dy0_q, dy0_d;
  logic [SCALE_W-1:0] sc0_q, sc0_d;
  logic [COORD_W:0]   dx_full, dy_full;

  logic [COORD_W-1:0] cx, ry, idx, gc;
  logic               v1_q, v1_d, ok1_q, ok1_d;
  logic [ROW_W-1:0]   ry1_q, ry1_d;
  logic [COL_W-1:0]   gc1_q, gc1_d;
  logic [ENTRY_W-1:0] code1_q, code1_d;

  logic [GLYPH_BITS-1:0] glyph;
  logic [GIDX_W-1:0]     bit_idx;
  logic                  pix_on;
  logic                  draw_q, draw_d, draw_valid_q, draw_valid_d;

`ifdef TEXT_LINE_BLINK_EN
  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  assign wr_entry = {wr_blink, wr_data};
`else
  assign wr_entry = wr_data;
`endif

  // Origin/scale shadow; the _d value is what a coincident pixel sees.
  always_comb begin
    h_ori_d = h_ori_q;
    v_ori_d = v_ori_q;
    scale_d = scale_q;
    if (frame_start) begin
      h_ori_d = h_ori;
      v_ori_d = v_ori;
      scale_d = scale_log2;
    end
  end

  always_comb begin
    cbuf_d = cbuf_q;
    if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_CHARS))) cbuf_d[wr_addr] = wr_entry;
  end

  // S0: offsets from origin; the borrow bit doubles as the left/above flag.
  always_comb begin
    dx_full = {1'b0, hpos} - {1'b0, h_ori_d};
    dy_full = {1'b0, vpos} - {1'b0, v_ori_d};
    v0_d    = pix_valid;
    neg0_d  = dx_full[COORD_W] | dy_full[COORD_W];
    dx0_d   = dx_full[COORD_W-1:0];
    dy0_d   = dy_full[COORD_W-1:0];
    sc0_d   = scale_d;
  end

  // S1: unscale, split into cell index and glyph column, read the buffer.
  always_comb begin
    cx      = dx0_q >> sc0_q;
    ry      = dy0_q >> sc0_q;
    idx     = cx / COORD_W'(CELL_W);
    gc      = cx % COORD_W'(CELL_W);
    v1_d    = v0_q;
    ok1_d   = v0_q && !neg0_q && (ry < COORD_W'(GLYPH_H)) &&
              (idx < COORD_W'(NUM_CHARS)) && (gc < COORD_W'(GLYPH_W));
    ry1_d   = ROW_W'(ry);
    gc1_d   = COL_W'(gc);
    code1_d = cbuf_q[AW'(idx)];
  end

  glyph_rom u_glyph_rom (
    .code    (code1_q[7:0]),
    .glyph_c (glyph)
  );

  // S2: pick the glyph bit.
  always_comb begin
    bit_idx = GIDX_W'(ry1_q) * GIDX_W'(GLYPH_W) + GIDX_W'(gc1_q);
    pix_on  = ok1_q && glyph[bit_idx];
`ifdef TEXT_LINE_BLINK_EN
    if (code1_q[ENTRY_W-1] && blink_phase_q) pix_on = 1'b0;
`endif
    draw_d       = v1_q && pix_on;
    draw_valid_d = v1_q;
  end

`ifdef TEXT_LINE_BLINK_EN
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_ori_q      <= '0;
      v_ori_q      <= '0;
      scale_q      <= '0;
      for (int i = 0; i < NUM_CHARS; i++) cbuf_q[i] <= ENTRY_W'(CHAR_SPACE);
      v0_q         <= 1'b0;
      neg0_q       <= 1'b0;
      dx0_q        <= '0;
      dy0_q        <= '0;
      sc0_q        <= '0;
      v1_q         <= 1'b0;
      ok1_q        <= 1'b0;
      ry1_q        <= '0;
      gc1_q        <= '0;
      code1_q      <= ENTRY_W'(CHAR_SPACE);
      draw_q       <= 1'b0;
      draw_valid_q <= 1'b0;
`ifdef TEXT_LINE_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      h_ori_q      <= h_ori_d;
      v_ori_q      <= v_ori_d;
      scale_q      <= scale_d;
      cbuf_q       <= cbuf_d;
      v0_q         <= v0_d;
      neg0_q       <= neg0_d;
      dx0_q        <= dx0_d;
      dy0_q        <= dy0_d;
      sc0_q        <= sc0_d;
      v1_q         <= v1_d;
      ok1_q        <= ok1_d;
      ry1_q        <= ry1_d;
      gc1_q        <= gc1_d;
      code1_q      <= code1_d;
      draw_q       <= draw_d;
      draw_valid_q <= draw_valid_d;
`ifdef TEXT_LINE_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign draw       = draw_q;
  assign draw_valid = draw_valid_q;

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed self-checking bench for text_line_renderer; blink steps run when TEXT_LINE_BLINK_EN is defined.
module tb_text_line_renderer;

  localparam int unsigned NCH = 12;
  localparam int unsigned CW  = 12;

  logic          clk, rst_n, frame_start, pix_valid, wr_en, wr_blink;
  logic [CW-1:0] h_ori, v_ori, hpos, vpos;
  logic [2:0]    scale_log2;
  logic [3:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          draw, draw_valid;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ho, vo, sc;
  logic [7:0] mbuf [NCH];

  text_line_renderer #(
    .NUM_CHARS (NCH),
    .COORD_W   (CW),
    .CHAR_GAP  (1),
`ifdef TEXT_LINE_BLINK_EN
    .BLINK_FRAMES (2),
`endif
    .SCALE_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .h_ori       (h_ori),
    .v_ori       (v_ori),
    .scale_log2  (scale_log2),
    .pix_valid   (pix_valid),
    .hpos        (hpos),
    .vpos        (vpos),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef TEXT_LINE_BLINK_EN
    .wr_blink    (wr_blink),
`endif
    .draw        (draw),
    .draw_valid  (draw_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference font rows, leftmost pixel in bit 6 of each 7-bit row.
  function automatic logic font_bit(input logic [7:0] ch, input int r, input int c);
    logic [48:0] v;
    case (ch)
      8'h41: v = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0111110, 7'b0100010, 7'b0100010, 7'b0100010};
      8'h42: v = {7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100};
      8'h43: v = {7'b0011100, 7'b0100010, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100010, 7'b0011100};
      8'h58: v = {7'b0100010, 7'b0100010, 7'b0010100, 7'b0001000, 7'b0010100, 7'b0100010, 7'b0100010};
      default: v = '0;
    endcase
    return v[(6 - r) * 7 + (6 - c)];
  endfunction

  function automatic logic exp_pix(input int h, input int v);
    int cx, ry, idx, gc;
    if (h < ho || v < vo) return 1'b0;
    cx  = (h - ho) >> sc;
    ry  = (v - vo) >> sc;
    idx = cx / 8;
    gc  = cx % 8;
    if (ry >= 7 || idx >= NCH || gc >= 7) return 1'b0;
    return font_bit(mbuf[idx], ry, gc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated pixel; result is due three edges after launch.
  task automatic probe(input int h, input int v, input logic exp, input string tag, input logic fs);
    hpos = CW'(h); vpos = CW'(v); pix_valid = 1'b1; frame_start = fs;
    tick();
    pix_valid = 1'b0; frame_start = 1'b0;
    tick();
    tick();
    check(tag, {30'b0, draw_valid, draw}, {30'b0, 1'b1, exp});
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d, input logic b);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; wr_blink = b;
    tick();
    wr_en = 1'b0; wr_blink = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; wr_en = 1'b0; wr_blink = 1'b0;
    h_ori = '0; v_ori = '0; hpos = '0; vpos = '0; scale_log2 = '0; wr_addr = '0; wr_data = '0;
    ho = 0; vo = 0; sc = 0;
    for (int i = 0; i < NCH; i++) mbuf[i] = 8'h20;

    // Reset state
    tick(); tick();
    check("reset_out", {30'b0, draw_valid, draw}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Step 1: blank line at (100,50), scale 0, with latency check
    h_ori = 12'd100; v_ori = 12'd50; scale_log2 = 3'd0;
    fs_pulse();
    ho = 100; vo = 50; sc = 0;
    hpos = 12'd100; vpos = 12'd50; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    check("lat_edge1", {31'b0, draw_valid}, 32'd0);
    tick();
    check("lat_edge2", {31'b0, draw_valid}, 32'd0);
    tick();
    check("lat_edge3", {30'b0, draw_valid, draw}, 32'd2);
    tick();
    check("lat_edge4", {31'b0, draw_valid}, 32'd0);
    for (int x = 96; x <= 131; x++) probe(x, 50, 1'b0, $sformatf("blank(%0d,50)", x), 1'b0);

    // Step 2: "AB" at scale 1
    wr(0, 8'h41, 1'b0); mbuf[0] = 8'h41;
    wr(1, 8'h42, 1'b0); mbuf[1] = 8'h42;
    scale_log2 = 3'd1;
    fs_pulse();
    sc = 1;
    probe(104, 50, 1'b1, "A_r0c2", 1'b0);
    probe(102, 50, 1'b0, "A_r0c1", 1'b0);
    probe(102, 56, 1'b1, "A_r3c1", 1'b0);
    probe(114, 52, 1'b0, "gap", 1'b0);
    probe(118, 50, 1'b1, "B_r0c1", 1'b0);
    for (int y = 50; y <= 63; y++)
      for (int x = 100; x <= 129; x++)
        probe(x, y, exp_pix(x, y), $sformatf("scanAB(%0d,%0d)", x, y), 1'b0);

    // Step 3: outside the line
    probe(99, 50, 1'b0, "left_of_origin", 1'b0);
    probe(100, 49, 1'b0, "above_origin", 1'b0);
    probe(100, 64, 1'b0, "below_line", 1'b0);
    probe(100 + NCH * 16, 50, 1'b0, "past_last_char", 1'b0);
    probe(100 + NCH * 16 + 4, 50, 1'b0, "past_last_char_c2", 1'b0);

    // Step 4: origin change only on frame_start; coincident pixel uses the new origin
    h_ori = 12'd200;
    probe(104, 50, 1'b1, "old_origin_kept", 1'b0);
    probe(204, 50, 1'b1, "coincident_fs", 1'b1);
    ho = 200;
    probe(104, 50, 1'b0, "old_origin_gone", 1'b0);

    // Step 5: write during S1 read is read-first
    hpos = 12'd210; vpos = 12'd54; pix_valid = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h43;
    tick();
    wr_en = 1'b0; pix_valid = 1'b0;
    tick();
    check("readfirst_old", {30'b0, draw_valid, draw}, 32'd3);
    tick();
    check("readfirst_new", {30'b0, draw_valid, draw}, 32'd2);
    mbuf[0] = 8'h43;
    wr(NCH, 8'h58, 1'b0);
    probe(210, 54, exp_pix(210, 54), "oob_write_ignored", 1'b0);
    probe(200 + NCH * 16 + 4, 50, 1'b0, "oob_idx_blank", 1'b0);

    // Step 6: asynchronous reset mid-stream
    hpos = 12'd204; vpos = 12'd50; pix_valid = 1'b1;
    tick(); tick(); tick();
    check("stream_lit", {30'b0, draw_valid, draw}, 32'd3);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {30'b0, draw_valid, draw}, 32'd0);
    pix_valid = 1'b0;
    tick();
    check("held_reset", {30'b0, draw_valid, draw}, 32'd0);
    rst_n = 1'b1;
    h_ori = '0; v_ori = '0; scale_log2 = '0;
    ho = 0; vo = 0; sc = 0;
    for (int i = 0; i < NCH; i++) mbuf[i] = 8'h20;
    probe(2, 0, 1'b0, "resume_buf_reset", 1'b0);
    probe(204, 50, 1'b0, "resume_origin_reset", 1'b0);

`ifdef TEXT_LINE_BLINK_EN
    // Blink: two drawn frames, two blank, two drawn; non-blinking entry always drawn
    wr(0, 8'h58, 1'b1);
    wr(1, 8'h58, 1'b0);
    probe(1, 0, 1'b1, "blink_f0", 1'b0);
    fs_pulse();
    probe(1, 0, 1'b1, "blink_f1", 1'b0);
    fs_pulse();
    probe(1, 0, 1'b0, "blink_f2", 1'b0);
    probe(9, 0, 1'b1, "noblink_f2", 1'b0);
    fs_pulse();
    probe(1, 0, 1'b0, "blink_f3", 1'b0);
    fs_pulse();
    probe(1, 0, 1'b1, "blink_f4", 1'b0);
    fs_pulse();
    probe(1, 0, 1'b1, "blink_f5", 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
